// File: rtl/tb_intr_gen_pkg.sv
// rtl/tb_intr_gen_pkg.sv - shared types, constants and line-pick helper for the random interrupt generator
package tb_intr_gen_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ASSERT  = 2'd2,
        HOLDOFF = 2'd3
    } intr_gen_state_e;

    localparam logic [15:0] LFSR_TAPS   = 16'hB400;
    localparam int          HOLDOFF_LEN = 4;

    // irq_vec bit order is {timer, software, external}
    localparam int IRQ_EXT_IDX   = 0;
    localparam int IRQ_SW_IDX    = 1;
    localparam int IRQ_TIMER_IDX = 2;
    localparam int NUM_IRQ       = 3;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } irq_pick_t;

    // Start at rnd (3 folds to 0) and walk upward mod 3 to the first permitted line.
    // Walking the candidates from farthest to nearest lets the nearest one win.
    function automatic irq_pick_t pick_line(input logic [NUM_IRQ-1:0] mask,
                                            input logic [1:0]         rnd);
        irq_pick_t r;
        int        start;
        int        i;
        r     = '0;
        start = (rnd == 2'd3) ? 0 : int'(rnd);
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            i = (start + k) % NUM_IRQ;
            if (mask[i]) begin
                r.found = 1'b1;
                r.idx   = 2'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tb_intr_gen_lfsr.sv
// rtl/tb_intr_gen_lfsr.sv - tb_lfsr16: free-running 16-bit Galois LFSR with zero-safe seed
module tb_lfsr16
    import tb_intr_gen_pkg::*;
#(
    parameter logic [15:0] Seed = 16'hACE1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [15:0] lfsr_o
);

    // An all-zero state would lock the LFSR, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF = (Seed == 16'h0000) ? 16'h0001 : Seed;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    assign lfsr_o = lfsr_q;

    // Shift every cycle; the generator's enable has no effect here.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            lfsr_q <= SEED_EFF;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/tb_intr_gen.sv
// rtl/tb_intr_gen.sv - random interrupt generator FSM; define TB_INTR_ACK_TIMEOUT_EN for the ack watchdog
module tb_intr_gen
    import tb_intr_gen_pkg::*;
#(
    parameter logic [15:0] LfsrSeed   = 16'hACE1,
    parameter int          AckTimeout = 1024
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                enable_i,
    input  logic [3:0]          intvl_i,
    input  logic [NUM_IRQ-1:0]  irq_mask_i,
    input  logic [NUM_IRQ-1:0]  intr_ack_i,
    output logic [NUM_IRQ-1:0]  irq_vec_o,
    output logic [15:0]         raise_cnt_o,
    output logic                timeout_o,
    output logic                active_o
);

    intr_gen_state_e    state_q;
    logic [7:0]         cnt_q;
    logic [1:0]         hold_q;
    logic [NUM_IRQ-1:0] irq_q;
    logic [15:0]        raise_q;
    logic [15:0]        lfsr;
    logic               run_ok;
    logic               acked;
    logic [7:0]         reload;
    irq_pick_t          pick;

    tb_lfsr16 #(
        .Seed   (LfsrSeed)
    ) u_lfsr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .lfsr_o (lfsr)
    );

    assign run_ok = enable_i && (intvl_i != 4'd0);
    assign reload = {intvl_i, lfsr[3:0]};
    assign pick   = pick_line(irq_mask_i, lfsr[1:0]);
    // Only the ack bit of the line currently held counts.
    assign acked  = |(intr_ack_i & irq_q);

`ifdef TB_INTR_ACK_TIMEOUT_EN
    logic [31:0] wd_q;
    logic        timeout_q;

    // Watchdog on ASSERT; an ack in the expiry cycle takes priority over the timeout.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else if (state_q != ASSERT || acked) begin
            wd_q <= '0;
        end else if (wd_q == 32'(AckTimeout - 1)) begin
            wd_q      <= '0;
            timeout_q <= 1'b1;
        end else begin
            wd_q <= wd_q + 32'd1;
        end
    end

    logic wd_expire;
    assign wd_expire = (state_q == ASSERT) && !acked && (wd_q == 32'(AckTimeout - 1));
    assign timeout_o = timeout_q;
`else
    logic wd_expire;
    assign wd_expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // Main sequencer: idle, count down a random interval, raise one line, hold off.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            irq_q   <= '0;
            raise_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (run_ok) begin
                        state_q <= WAIT;
                        cnt_q   <= reload;
                    end
                end
                WAIT: begin
                    if (!run_ok) begin
                        state_q <= IDLE;
                    end else if (cnt_q == 8'd0) begin
                        if (pick.found) begin
                            irq_q   <= NUM_IRQ'(1) << pick.idx;
                            raise_q <= raise_q + 16'd1;
                            state_q <= ASSERT;
                        end else begin
                            cnt_q <= reload;
                        end
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                ASSERT: begin
                    if (acked || wd_expire) begin
                        irq_q   <= '0;
                        hold_q  <= 2'(HOLDOFF_LEN - 1);
                        state_q <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (hold_q == 2'd0) begin
                        if (run_ok) begin
                            state_q <= WAIT;
                            cnt_q   <= reload;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        hold_q <= hold_q - 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign irq_vec_o   = irq_q;
    assign raise_cnt_o = raise_q;
    assign active_o    = (state_q != IDLE);

endmodule

// File: tb/tb_tb_intr_gen.sv
// tb/tb_tb_intr_gen.sv - directed self-checking bench for tb_intr_gen (TB_INTR_ACK_TIMEOUT_EN selects the watchdog case)
module tb_tb_intr_gen;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    logic        enable_i = 1'b0;
    logic [3:0]  intvl_i = 4'd0;
    logic [2:0]  irq_mask_i = 3'b000;
    logic [2:0]  intr_ack_i = 3'b000;
    logic [2:0]  irq_vec_o;
    logic [15:0] raise_cnt_o;
    logic        timeout_o;
    logic        active_o;

    int n_checks = 0;
    int n_fail   = 0;

    tb_intr_gen #(
        .LfsrSeed   (16'hACE1),
        .AckTimeout (16)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .enable_i    (enable_i),
        .intvl_i     (intvl_i),
        .irq_mask_i  (irq_mask_i),
        .intr_ack_i  (intr_ack_i),
        .irq_vec_o   (irq_vec_o),
        .raise_cnt_o (raise_cnt_o),
        .timeout_o   (timeout_o),
        .active_o    (active_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        rst_ni     = 1'b1;
        enable_i   = 1'b0;
        intvl_i    = 4'd0;
        irq_mask_i = 3'b000;
        intr_ack_i = 3'b000;
        repeat (2) tick();
        rst_ni = 1'b0;
        tick();
    endtask

    task automatic wait_irq(input int max, output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        while (cycles < max && !ok) begin
            tick();
            cycles++;
            if (irq_vec_o != 3'b000) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b1;
        repeat (3) tick();
        n_checks++; if (irq_vec_o !== 3'b000) begin n_fail++; $display("FAIL reset_irq: got %b expected 000", irq_vec_o); end
        n_checks++; if (raise_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_raise: got %0d expected 0", raise_cnt_o); end
        n_checks++; if (timeout_o !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_o); end
        n_checks++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active_o); end
        rst_ni = 1'b0;
        tick();
    endtask

    task automatic test_first_raise();
        int t, t_act, expiry;
        bit ok;
        do_reset();
        irq_mask_i = 3'b111;
        intvl_i    = 4'd2;
        enable_i   = 1'b1;
        t = 0; t_act = -1; ok = 1'b0;
        while (t < 80 && !ok) begin
            tick();
            t++;
            if (active_o && t_act < 0) t_act = t;
            if (irq_vec_o != 3'b000) ok = 1'b1;
        end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL first_irq_seen: got %b expected 1", ok); end
        // t - t_act spans the load cycle of WAIT plus the one-cycle assert latency
        expiry = t - t_act - 1;
        n_checks++; if (expiry < 32 || expiry > 47) begin n_fail++; $display("FAIL first_latency: got %0d expected 32..47", expiry); end
        n_checks++; if ($countones(irq_vec_o) !== 1) begin n_fail++; $display("FAIL first_onehot: got %b expected one bit", irq_vec_o); end
        n_checks++; if (raise_cnt_o !== 16'd1) begin n_fail++; $display("FAIL first_raise_cnt: got %0d expected 1", raise_cnt_o); end
        intr_ack_i = irq_vec_o;
        enable_i   = 1'b0;
        tick();
        intr_ack_i = 3'b000;
        n_checks++; if (irq_vec_o !== 3'b000) begin n_fail++; $display("FAIL first_ack_drop: got %b expected 000", irq_vec_o); end
        t = 0;
        while (t < 10 && active_o) begin tick(); t++; end
        n_checks++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL first_back_idle: got %b expected 0", active_o); end
    endtask

    task automatic test_single_line();
        int cyc;
        bit ok, all_ok, all_sw;
        do_reset();
        irq_mask_i = 3'b010;
        intvl_i    = 4'd1;
        enable_i   = 1'b1;
        all_ok = 1'b1; all_sw = 1'b1;
        for (int r = 0; r < 20; r++) begin
            wait_irq(80, cyc, ok);
            if (!ok) all_ok = 1'b0;
            if (irq_vec_o !== 3'b010) all_sw = 1'b0;
            intr_ack_i = 3'b010;
            tick();
            intr_ack_i = 3'b000;
        end
        n_checks++; if (all_ok !== 1'b1) begin n_fail++; $display("FAIL sw_all_raised: got %b expected 1", all_ok); end
        n_checks++; if (all_sw !== 1'b1) begin n_fail++; $display("FAIL sw_only_bit1: got %b expected 1", all_sw); end
        n_checks++; if (raise_cnt_o !== 16'd20) begin n_fail++; $display("FAIL sw_raise_cnt: got %0d expected 20", raise_cnt_o); end
    endtask

    task automatic test_wrong_ack_holdoff();
        int cyc;
        bit ok, held, hold_ok;
        do_reset();
        irq_mask_i = 3'b001;
        intvl_i    = 4'd1;
        enable_i   = 1'b1;
        wait_irq(60, cyc, ok);
        n_checks++; if (irq_vec_o !== 3'b001) begin n_fail++; $display("FAIL ext_raise: got %b expected 001", irq_vec_o); end
        intr_ack_i = 3'b100;
        held = 1'b1;
        repeat (5) begin tick(); if (irq_vec_o !== 3'b001) held = 1'b0; end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL ext_wrong_ack_held: got %b expected 1", held); end
        intr_ack_i = 3'b001;
        enable_i   = 1'b0;
        tick();
        intr_ack_i = 3'b000;
        n_checks++; if (irq_vec_o !== 3'b000) begin n_fail++; $display("FAIL ext_ack_drop: got %b expected 000", irq_vec_o); end
        hold_ok = active_o;
        repeat (3) begin tick(); if (!active_o || irq_vec_o != 3'b000) hold_ok = 1'b0; end
        n_checks++; if (hold_ok !== 1'b1) begin n_fail++; $display("FAIL holdoff_4_cycles: got %b expected 1", hold_ok); end
        tick();
        n_checks++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL holdoff_end_idle: got %b expected 0", active_o); end
    endtask

    task automatic test_enable_fall_assert();
        int cyc;
        bit ok, held;
        do_reset();
        irq_mask_i = 3'b100;
        intvl_i    = 4'd1;
        enable_i   = 1'b1;
        wait_irq(60, cyc, ok);
        n_checks++; if (irq_vec_o !== 3'b100) begin n_fail++; $display("FAIL timer_raise: got %b expected 100", irq_vec_o); end
        enable_i = 1'b0;
        held = 1'b1;
        repeat (10) begin tick(); if (irq_vec_o !== 3'b100) held = 1'b0; end
        n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL en_fall_held: got %b expected 1", held); end
        intr_ack_i = 3'b100;
        tick();
        intr_ack_i = 3'b000;
        repeat (4) tick();
        n_checks++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL en_fall_idle: got %b expected 0", active_o); end
    endtask

    task automatic test_enable_fall_wait();
        bit quiet;
        do_reset();
        irq_mask_i = 3'b111;
        intvl_i    = 4'd1;
        enable_i   = 1'b1;
        repeat (3) tick();
        n_checks++; if (active_o !== 1'b1) begin n_fail++; $display("FAIL wait_active: got %b expected 1", active_o); end
        enable_i = 1'b0;
        tick();
        n_checks++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL wait_fall_idle: got %b expected 0", active_o); end
        quiet = 1'b1;
        repeat (40) begin tick(); if (irq_vec_o != 3'b000) quiet = 1'b0; end
        n_checks++; if (quiet !== 1'b1 || raise_cnt_o !== 16'd0) begin n_fail++; $display("FAIL wait_fall_no_raise: got %b/%0d expected 1/0", quiet, raise_cnt_o); end
        enable_i = 1'b1;
        intvl_i  = 4'd0;
        repeat (20) tick();
        n_checks++; if (active_o !== 1'b0) begin n_fail++; $display("FAIL intvl_zero_idle: got %b expected 0", active_o); end
    endtask

    task automatic test_mask_zero();
        bit quiet;
        do_reset();
        irq_mask_i = 3'b000;
        intvl_i    = 4'd1;
        enable_i   = 1'b1;
        quiet = 1'b1;
        repeat (200) begin tick(); if (irq_vec_o != 3'b000) quiet = 1'b0; end
        n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL mask0_quiet: got %b expected 1", quiet); end
        n_checks++; if (raise_cnt_o !== 16'd0) begin n_fail++; $display("FAIL mask0_raise: got %0d expected 0", raise_cnt_o); end
        n_checks++; if (active_o !== 1'b1) begin n_fail++; $display("FAIL mask0_active: got %b expected 1", active_o); end
    endtask

    task automatic test_ack_timeout();
        int cyc, high;
        bit ok, sticky;
        do_reset();
        irq_mask_i = 3'b111;
        intvl_i    = 4'd1;
        enable_i   = 1'b1;
        wait_irq(60, cyc, ok);
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL to_raise: got %b expected 1", ok); end
`ifdef TB_INTR_ACK_TIMEOUT_EN
        enable_i = 1'b0;
        high = 1;
        while (high < 40 && irq_vec_o != 3'b000) begin tick(); if (irq_vec_o != 3'b000) high++; end
        n_checks++; if (high !== 16) begin n_fail++; $display("FAIL to_hold_cycles: got %0d expected 16", high); end
        sticky = 1'b1;
        repeat (20) begin tick(); if (timeout_o !== 1'b1) sticky = 1'b0; end
        n_checks++; if (sticky !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b expected 1", sticky); end
`else
        high = 1;
        repeat (40) begin tick(); if (irq_vec_o != 3'b000) high++; end
        n_checks++; if (high !== 41) begin n_fail++; $display("FAIL noto_held: got %0d expected 41", high); end
        sticky = 1'b1;
        repeat (5) begin tick(); if (timeout_o !== 1'b0) sticky = 1'b0; end
        n_checks++; if (sticky !== 1'b1) begin n_fail++; $display("FAIL noto_flag_low: got %b expected 1", sticky); end
        intr_ack_i = irq_vec_o;
        tick();
        intr_ack_i = 3'b000;
`endif
    endtask

    initial begin
        tick();
        test_reset();
        test_first_raise();
        test_single_line();
        test_wrong_ack_holdoff();
        test_enable_fall_assert();
        test_enable_fall_wait();
        test_mask_zero();
        test_ack_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_intr_gen.md
TB_INTR_GEN -- requirements
Module: tb_intr_gen

Interface
REQ-001 SHALL have parameter LfsrSeed, default 16'hACE1, LFSR reset value; a zero value is replaced by 16'h0001.
REQ-002 SHALL have parameter AckTimeout, default 1024, cycles an IRQ may stay unacknowledged before it is dropped.
REQ-003 SHALL have port clk_i  input  1  clock.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port enable_i  input  1  generator enable (err_enable_vec[2] from the data memory model).
REQ-006 SHALL have port intvl_i  input  4  interval coarse value (INTR_INTVL plusarg); 0 means never raise.
REQ-007 SHALL have port irq_mask_i  input  3  per-line permit, bit order {timer, software, external}.
REQ-008 SHALL have port intr_ack_i  input  3  per-line acknowledge from the memory-mapped interrupt-clear register.
REQ-009 SHALL have port irq_vec_o  output  3  interrupt lines to the core, same bit order as irq_mask_i.
REQ-010 SHALL have port raise_cnt_o  output  16  count of interrupts raised.
REQ-011 SHALL have port timeout_o  output  1  sticky flag, set when an interrupt is dropped unacknowledged.
REQ-012 SHALL have port active_o  output  1  high whenever the state is not IDLE.

Function
REQ-013 SHALL step a 16-bit Galois LFSR (taps 16'hB400) every cycle, independent of enable_i.
REQ-014 SHALL implement the states IDLE, WAIT, ASSERT, HOLDOFF.
REQ-015 IDLE -> WAIT when enable_i=1 and intvl_i!=0; the 8-bit down-counter loads {intvl_i, lfsr[3:0]}.
REQ-016 WAIT: counter decrements each cycle; returns to IDLE at once if enable_i=0 or intvl_i=0.
REQ-017 WAIT, counter==0: pick start index lfsr[1:0] (3 maps to 0), then search upward mod 3 for the first line set in irq_mask_i.
REQ-018 When that search finds a line, the block SHALL set that irq_vec_o bit, increment raise_cnt_o and go to ASSERT.
REQ-019 If irq_mask_i==0 at expiry, the block SHALL reload the counter and stay in WAIT with no raise.
REQ-020 Expiry-to-assert latency SHALL be exactly 1 cycle; at most one irq_vec_o bit is ever high.
REQ-021 ASSERT: hold the line until the matching intr_ack_i bit is high, sampled; ack bits of other lines are ignored.
REQ-022 The line SHALL deassert the cycle after ack; then go to HOLDOFF.
REQ-023 ASSERT SHALL ignore enable_i falling; a raised interrupt is always held until ack or timeout.
REQ-024 HOLDOFF SHALL last 4 cycles with all lines low, then go to WAIT (reload) if enable_i=1 and intvl_i!=0, else to IDLE.
REQ-025 raise_cnt_o SHALL wrap from 16'hFFFF to 0 without flag.
REQ-026 Ack arriving in the same cycle as the timeout expiry SHALL be treated as an ack; timeout_o is not set.

Reset
REQ-027 On reset the block SHALL be in state IDLE with lfsr=LfsrSeed (substituted as in REQ-001), irq_vec_o=0, raise_cnt_o=0, timeout_o=0, active_o=0 and counters=0.
REQ-028 Reset asserted mid-ASSERT SHALL drop the line immediately (asynchronous).

Configuration
REQ-029 With TB_INTR_ACK_TIMEOUT_EN defined, an ASSERT watchdog SHALL count cycles; at AckTimeout it drops the line, sets timeout_o, and goes to HOLDOFF.
REQ-030 Without TB_INTR_ACK_TIMEOUT_EN, ASSERT SHALL wait for ack indefinitely, and timeout_o SHALL be tied to 0.

Structure
REQ-031 A shared TB package SHALL hold the state enum intr_gen_state_e, the LFSR tap constant, the HOLDOFF length (4) and the irq bit-index constants.
REQ-032 The LFSR SHALL be a sub-module tb_lfsr16 (seed parameter, free-running, 16-bit output).
REQ-033 The instantiating testbench SHALL drive irq_vec from irq_vec_o and connect intr_ack_i to the data model's intr_ack.

Verification
REQ-034 intvl_i=2, mask=3'b111, enable=1, immediate ack -> first irq within 32..47 cycles of enable; exactly one bit high; raise_cnt_o=1.
REQ-035 mask=3'b010, 20 raises -> only irq_vec_o[1] ever asserts; raise_cnt_o=20.
REQ-036 Raise on bit 0, ack bit 2 only -> line stays high; ack bit 0 -> low next cycle, 4 idle cycles follow.
REQ-037 Build with TB_INTR_ACK_TIMEOUT_EN, AckTimeout=16, never ack -> line drops after 16 cycles; timeout_o=1 and stays 1.
REQ-038 enable_i falls during ASSERT -> line held until ack, then IDLE, active_o=0; enable_i falls during WAIT -> IDLE next cycle with no raise.
REQ-039 mask=0 with intvl_i=1 for 200 cycles -> irq_vec_o stays 0, raise_cnt_o=0, active_o=1.
